// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : div_pkg                                                        |
// | Shared types and defaults for the divider arbiter.                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package div_pkg;

    localparam int DIV_N_DEFAULT       = 16;
    localparam int DIV_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_pick                                                         |
// | Combinational round-robin picker: first set request at or above ptr_i,   |
// | wrapping past NREQ-1. Returns one-hot grant and its index.               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    localparam int c_sum_w = IW + 1;

    logic [c_sum_w-1:0] w_sum;
    logic [IW-1:0]      w_k;
    logic               w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Wrap explicitly so non-power-of-two NREQ works.
            w_sum = {1'b0, ptr_i} + c_sum_w'(i);
            if (w_sum >= c_sum_w'(NREQ)) begin
                w_sum = w_sum - c_sum_w'(NREQ);
            end
            w_k = w_sum[IW-1:0];
            if (!w_found && req_i[w_k]) begin
                w_found    = 1'b1;
                gnt_o[w_k] = 1'b1;
                idx_o      = w_k;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : div_arbiter                                                     |
// | Round-robin sharing of one iterative divider among NREQ requesters.      |
// | Optional watchdog: define DIV_TIMEOUT_EN (adds timeout_o).               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module div_arbiter
    import div_pkg::*;
#(
    parameter int N       = DIV_N_DEFAULT,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*N-1:0] dividend_i,
    input  logic [NREQ*N-1:0] divisor_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [N-1:0]      q_o,
    output logic              exc_o,
    output logic              busy_o,
    output logic              div_req_o,
    output logic [N-1:0]      div_dividend_o,
    output logic [N-1:0]      div_divisor_o,
    input  logic              div_ready_i,
    input  logic [N-1:0]      div_q_i
`ifdef DIV_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);
    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    div_state_t          r_state;
    div_state_t          w_state_nxt;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  r_owner;
    logic [NREQ-1:0]     r_owner_oh;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic [NREQ-1:0]     w_pick_gnt;
    logic [N-1:0]        r_dividend;
    logic [N-1:0]        r_divisor;
    logic [N-1:0]        r_q;
    logic                r_exc;
    logic                w_take;
    logic                w_div_zero;

`ifdef DIV_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_timeout;
    logic                w_expire;

    assign w_expire  = (r_cnt == c_cnt_w'(TIMEOUT - 1));
    assign timeout_o = r_timeout;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_idx_w)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (r_rr_ptr),
        .gnt_o (w_pick_gnt),
        .idx_o (w_pick_idx)
    );

    // A lingering ready from the previous op must drain before a new grant.
    assign w_take     = (|req_i) && !div_ready_i;
    assign w_div_zero = (r_divisor == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (div_ready_i) begin
                    w_state_nxt = S_RESP;
                end
`ifdef DIV_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_nxt = S_RESP;
                end
`endif
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant_o     = '0;
        rsp_valid_o = '0;
        div_req_o   = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                grant_o   = r_owner_oh;
                div_req_o = 1'b1;
            end
            S_RESP:  rsp_valid_o = r_owner_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_q        <= '0;
            r_exc      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_owner    <= w_pick_idx;
                        r_owner_oh <= w_pick_gnt;
                        r_dividend <= dividend_i[w_pick_idx*N +: N];
                        r_divisor  <= divisor_i[w_pick_idx*N +: N];
                    end
                end
                S_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // Zero divisor is flagged locally; the divider's quotient is discarded.
                    if (div_ready_i) begin
                        r_q   <= w_div_zero ? '0 : div_q_i;
                        r_exc <= w_div_zero;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (w_expire) begin
                        r_q       <= '1;
                        r_exc     <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_rr_ptr <= (r_owner == c_idx_w'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign q_o            = r_q;
    assign exc_o          = r_exc;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;

endmodule : div_arbiter
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_div_arbiter                                                  |
// | Randomized bench for div_arbiter with a behavioural divider and a        |
// | round-robin scoreboard. Covers DIV_TIMEOUT_EN when defined.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_div_arbiter;
    localparam int N    = 16;
    localparam int NREQ = 4;
`ifdef DIV_TIMEOUT_EN
    localparam int TMO  = 16;
`else
    localparam int TMO  = 1024;
`endif

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] dvd;
    logic [NREQ*N-1:0] dvs;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   rsp_valid_o;
    logic [N-1:0]      q_o;
    logic              exc_o;
    logic              busy_o;
    logic              div_req_o;
    logic [N-1:0]      div_dividend_o;
    logic [N-1:0]      div_divisor_o;
    logic              div_ready;
    logic [N-1:0]      div_q;
`ifdef DIV_TIMEOUT_EN
    logic              timeout_o;
`endif

    div_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_i          (req),
        .dividend_i     (dvd),
        .divisor_i      (dvs),
        .grant_o        (grant_o),
        .rsp_valid_o    (rsp_valid_o),
        .q_o            (q_o),
        .exc_o          (exc_o),
        .busy_o         (busy_o),
        .div_req_o      (div_req_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_ready_i    (div_ready),
        .div_q_i        (div_q)
`ifdef DIV_TIMEOUT_EN
        ,
        .timeout_o      (timeout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester-side view of the operands each slot is presenting.
    logic [N-1:0] opa [NREQ];
    logic [N-1:0] opb [NREQ];
    logic [NREQ-1:0] hold;

    // Behavioural divider.
    bit div_busy = 0;
    bit div_dead = 0;
    int force_d  = 0;
    int div_d    = 1;

    initial begin
        logic [N-1:0] a, b;
        int d;
        div_ready = 1'b0;
        div_q     = '0;
        forever begin
            @(negedge clk);
            if (rstn && div_req_o && !div_dead) begin
                a = div_dividend_o;
                b = div_divisor_o;
                div_busy = 1;
                d = (force_d != 0) ? force_d : int'($urandom_range(1, 4));
                div_d = d;
                repeat (d) @(posedge clk);
                #1;
                div_ready = 1'b1;
                div_q     = (b == 0) ? 16'hDEAD : a / b;
                repeat (1 + $urandom_range(0, 2)) @(posedge clk);
                #1;
                div_ready = 1'b0;
                div_q     = '0;
                div_busy  = 0;
            end
        end
    end

    // Requesters drop their request once granted unless told to hold it.
    initial begin
        logic [NREQ-1:0] g;
        forever begin
            @(negedge clk);
            g = grant_o;
            if (g != 0) begin
                @(posedge clk);
                #1;
                req = req & ~(g & ~hold);
            end
        end
    end

    // Reference model: round-robin from ptr, one outstanding op.
    function automatic int rr_ref(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    logic [NREQ-1:0] prev_req;
    logic            prev_ready;
    int              ptr = 0;
    bit              outst = 0;
    int              exp_slot;
    logic [N-1:0]    exp_q;
    bit              exp_exc;
    bit              exp_tmo;
    int              g_cyc;
    int              n_rsp = 0;
    int              gq[$];
    int              mon_e;

    always @(negedge clk) begin
        if (!rstn) begin
            outst = 0;
            ptr   = 0;
        end else begin
            if (grant_o != 0) begin
                mon_e = rr_ref(prev_req, ptr);
                check("grant_owner", 32'(grant_o), (mon_e < 0) ? 32'd0 : (32'd1 << mon_e));
                check("grant_drain", 32'(prev_ready), 32'd0);
                check("grant_overlap", 32'(outst), 32'd0);
                for (int i = 0; i < NREQ; i++) if (grant_o[i]) begin gq.push_back(i); break; end
                if (mon_e < 0) mon_e = 0;
                check("issue_req", 32'(div_req_o), 32'd1);
                check("issue_dividend", 32'(div_dividend_o), 32'(opa[mon_e]));
                check("issue_divisor", 32'(div_divisor_o), 32'(opb[mon_e]));
                exp_slot = mon_e;
                exp_tmo  = div_dead;
                if (div_dead) begin
                    exp_q = '1; exp_exc = 1;
                end else if (opb[mon_e] == 0) begin
                    exp_q = '0; exp_exc = 1;
                end else begin
                    exp_q = opa[mon_e] / opb[mon_e]; exp_exc = 0;
                end
                g_cyc = cyc;
                outst = 1;
            end
            if (rsp_valid_o != 0) begin
                check("rsp_expected", 32'(outst), 32'd1);
                if (outst) begin
                    check("rsp_slot", 32'(rsp_valid_o), 32'd1 << exp_slot);
                    check("rsp_q", 32'(q_o), 32'(exp_q));
                    check("rsp_exc", 32'(exc_o), 32'(exp_exc));
                    check("rsp_latency", cyc - g_cyc, exp_tmo ? 1 + TMO : 1 + div_d);
                    ptr   = (exp_slot + 1) % NREQ;
                    outst = 0;
                    n_rsp++;
                end
            end
        end
        prev_req   = req;
        prev_ready = div_ready;
    end

    task automatic set_op(input int slot, input logic [N-1:0] a, input logic [N-1:0] b);
        opa[slot] = a;
        opb[slot] = b;
        dvd[slot*N +: N] = a;
        dvs[slot*N +: N] = b;
    endtask

    task automatic post(input int slot, input logic [N-1:0] a, input logic [N-1:0] b);
        set_op(slot, a, b);
        req[slot] = 1'b1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((((req & ~hold) != 0) || outst || busy_o || div_busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("wait_bound", 32'(n < limit), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_grant"}, 32'(grant_o), 32'd0);
        check({tag, "_rsp"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_q"}, 32'(q_o), 32'd0);
        check({tag, "_exc"}, 32'(exc_o), 32'd0);
        check({tag, "_divreq"}, 32'(div_req_o), 32'd0);
        check({tag, "_dvd"}, 32'(div_dividend_o), 32'd0);
        check({tag, "_dvs"}, 32'(div_divisor_o), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int base, n;
        rstn = 1'b0;
        req  = '0;
        dvd  = '0;
        dvs  = '0;
        hold = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single requester: grant one cycle later.
        post(0, 16'd100, 16'd7);
        @(posedge clk);
        @(negedge clk);
        check("t1_grant_next", 32'(grant_o), 32'h1);
        wait_done(100);
        check("t1_q_hold", 32'(q_o), 32'd14);

        // All four at once from rr_ptr=0.
        do_reset();
        gq.delete();
        post(0, 16'd50, 16'd5);
        post(1, 16'd81, 16'd9);
        post(2, 16'd65535, 16'd1);
        post(3, 16'd3, 16'd4);
        wait_done(200);
        for (int k = 0; k < 4; k++) check("t2_order", gq.size() > k ? gq[k] : -1, k);
        for (int s = 0; s < NREQ; s++) post(s, 16'($urandom), 16'($urandom_range(1, 300)));
        wait_done(200);
        check("t2_next_round", gq.size() > 4 ? gq[4] : -1, 0);

        // Divide by zero, then a clean op.
        post(2, 16'd1234, 16'd0);
        wait_done(100);
        check("t3_exc", 32'(exc_o), 32'd1);
        post(2, 16'd9, 16'd3);
        wait_done(100);
        check("t3_exc_clear", 32'(exc_o), 32'd0);
        check("t3_q", 32'(q_o), 32'd3);

        // Requesters 1 and 3 held continuously.
        gq.delete();
        hold = 4'b1010;
        set_op(1, 16'd777, 16'd7);
        set_op(3, 16'd1000, 16'd8);
        req[1] = 1'b1;
        req[3] = 1'b1;
        base = n_rsp;
        n = 0;
        while (n_rsp - base < 6 && n < 300) begin @(posedge clk); n++; end
        check("t4_bound", 32'(n < 300), 32'd1);
        #1;
        req  = '0;
        hold = '0;
        wait_done(100);
        for (int j = 1; j < 6 && j < gq.size(); j++) check("t4_alternate", 32'(gq[j] == gq[j-1]), 32'd0);

        // Reset while waiting on the divider.
        force_d = 12;
        post(1, 16'd200, 16'd10);
        n = 0;
        while (!div_req_o && n < 50) begin @(posedge clk); n++; end
        check("t5_issue_bound", 32'(n < 50), 32'd1);
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_idle_outputs("t5_abort");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        force_d = 0;
        n = 0;
        while (div_busy && n < 50) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        post(1, 16'd200, 16'd10);
        wait_done(100);
        check("t5_q_after", 32'(q_o), 32'd20);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            for (int s = 0; s < NREQ; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    post(s, 16'($urandom),
                         ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000)));
                end
            end
            wait_done(300);
        end

`ifdef DIV_TIMEOUT_EN
        // Stuck divider trips the watchdog.
        check("t6_tmo_clear", 32'(timeout_o), 32'd0);
        div_dead = 1;
        post(0, 16'd77, 16'd7);
        wait_done(100);
        div_dead = 0;
        check("t6_tmo_set", 32'(timeout_o), 32'd1);
        check("t6_q", 32'(q_o), 32'hFFFF);
        post(0, 16'd77, 16'd7);
        wait_done(100);
        check("t6_tmo_sticky", 32'(timeout_o), 32'd1);
        check("t6_q_after", 32'(q_o), 32'd11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_arbiter
`default_nettype wire
